mult_div: RTL and testbench
===========================

MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 The block SHALL have parameter MULT_CYCLES, default 5, giving the BUSY length for MULT/MULTU.
REQ-002 The block SHALL have parameter DIV_CYCLES, default 10, giving the BUSY length for DIV/DIVU.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port D1, input, 32 bits: forwarded rs operand from the E stage.
REQ-006 The block SHALL have port D2, input, 32 bits: forwarded rt operand from the E stage.
REQ-007 The block SHALL have port MDOP, input, 3 bits, encoded as:
- 000 none
- 001 MULT
- 010 MULTU
- 011 DIV
- 100 DIVU
- 101 MTHI
- 110 MTLO
- 111 reserved, treated as none
REQ-008 The block SHALL have port START, input, 1 bit: qualifies MDOP 001-100 for one cycle.
REQ-009 The block SHALL have port BUSY, output, 1 bit: an operation is in flight; the hazard unit stalls any MDOP instruction in E while START or BUSY is high.
REQ-010 The block SHALL have port HI, output, 32 bits: architectural HI register.
REQ-011 The block SHALL have port LO, output, 32 bits: architectural LO register.

Function
REQ-012 The block SHALL implement two states, IDLE and RUN, plus a cycle counter, operand latches and an op latch.
REQ-013 In IDLE, a rising edge with START=1 and MDOP in 001-100 SHALL:
- latch D1, D2 and MDOP;
- load the counter with MULT_CYCLES or DIV_CYCLES;
- enter RUN.
REQ-014 BUSY SHALL equal 1 exactly while in RUN, so BUSY is high for exactly N cycles (N = loaded count), starting the cycle after the START edge.
REQ-015 In RUN the counter SHALL decrement each edge; at the edge where the counter goes from 1 to 0, the block SHALL write HI/LO and return to IDLE, so new HI/LO and BUSY=0 become visible together.
REQ-016 MULT SHALL perform a signed 32x32->64 multiply (HI = bits 63:32, LO = bits 31:0); MULTU SHALL perform the same multiply unsigned.
REQ-017 DIV SHALL set LO = signed quotient truncated toward zero and HI = remainder with the sign of the dividend; DIVU SHALL set LO and HI to the unsigned quotient and remainder.
REQ-018 For DIV/DIVU with latched D2=0, the block SHALL still hold BUSY for DIV_CYCLES and SHALL leave HI/LO unchanged.
REQ-019 For DIV with D1=0x80000000 and D2=0xFFFFFFFF, the block SHALL produce LO=0x80000000 and HI=0x00000000.
REQ-020 In IDLE, MDOP=101 SHALL write HI<=D1 and MDOP=110 SHALL write LO<=D1 at the edge, regardless of START.
REQ-021 In RUN, START, MTHI and MTLO SHALL be ignored; the operation in flight and its latched operands SHALL be unaffected by changes on D1/D2/MDOP.
REQ-022 START with MDOP 000, 101, 110 or 111 SHALL NOT enter RUN.
REQ-023 HI/LO SHALL change only at the completion edge (REQ-015), on MTHI/MTLO in IDLE (REQ-020), or on reset.
REQ-024 The outputs SHALL be register outputs with no combinational path from inputs to BUSY, HI or LO.

Reset
REQ-025 On a rising edge with reset=1, in any state including mid-RUN, the block SHALL:
- set HI=0, LO=0, BUSY=0 and counter=0;
- clear all latches;
- go to IDLE;
- discard any in-flight result.
REQ-026 Reset SHALL take priority over START, MTHI and MTLO in the same cycle.

Verification
REQ-027 MULT, D1=0xFFFFFFFE, D2=0x00000003 -> BUSY high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-028 MULTU, same operands -> after 5 busy cycles, HI=0x00000002, LO=0xFFFFFFFA.
REQ-029 DIV, D1=0xFFFFFFF9, D2=0x00000002 -> BUSY high for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-030 DIVU with D2=0 after MTHI 0x12345678 and MTLO 0x9ABCDEF0 -> BUSY high for 10 cycles, HI/LO unchanged.
REQ-031 MULTU in flight, with START+DIV and MTLO 0xDEADBEEF applied at busy cycle 2 -> both ignored; final result equals the MULTU product.
REQ-032 Reset at busy cycle 3 of a DIV -> next cycle BUSY=0, HI=0, LO=0; a subsequent MULT completes normally in 5 cycles.

Source files
------------

// File: rtl/mult_div_if.sv
// Handshake and result bundle between the E stage and the HI/LO unit.
// The master drives operands and ops; the slave returns BUSY, HI and LO.
interface mult_div_if;
  logic [31:0] D1;
  logic [31:0] D2;
  logic [2:0]  MDOP;
  logic        START;
  logic        BUSY;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output D1, D2, MDOP, START,
    input  BUSY, HI, LO
  );

  modport slave (
    input  D1, D2, MDOP, START,
    output BUSY, HI, LO
  );
endinterface

// File: rtl/mult_div.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO pair.
// Results are computed from latched operands and committed on the last busy edge.
module mult_div #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  mult_div_if.slave md
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [2:0]    op_q, op_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  logic          go;
  logic          go_div;
  logic [63:0]   prod_s;
  logic [63:0]   prod_u;
  logic [31:0]   qs, rs, qu, ru;
  logic          b_zero;
  logic          ovf;
  logic [31:0]   res_hi, res_lo;
  logic          res_wr;

  assign go = md.START &&
              (md.MDOP >= OP_MULT) &&
              (md.MDOP <= OP_DIVU);
  assign go_div = (md.MDOP == OP_DIV) ||
                  (md.MDOP == OP_DIVU);

  assign prod_s = $signed({{32{a_q[31]}}, a_q}) *
                  $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  assign b_zero = (b_q == 32'd0);
  // The only signed quotient that does not fit in 32 bits.
  assign ovf = (a_q == 32'h8000_0000) &&
               (b_q == 32'hFFFF_FFFF);

  always_comb begin
    qs = 32'd0;
    rs = 32'd0;
    qu = 32'd0;
    ru = 32'd0;
    if (!b_zero) begin
      qu = a_q / b_q;
      ru = a_q % b_q;
      if (ovf) begin
        qs = a_q;
        rs = 32'd0;
      end else begin
        qs = 32'($signed(a_q) / $signed(b_q));
        rs = 32'($signed(a_q) % $signed(b_q));
      end
    end
  end

  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    res_wr = 1'b0;
    unique case (1'b1)
      (op_q == OP_MULT): begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
        res_wr = 1'b1;
      end
      (op_q == OP_MULTU): begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
        res_wr = 1'b1;
      end
      (op_q == OP_DIV): begin
        res_hi = rs;
        res_lo = qs;
        res_wr = !b_zero;
      end
      (op_q == OP_DIVU): begin
        res_hi = ru;
        res_lo = qu;
        res_wr = !b_zero;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          a_d     = md.D1;
          b_d     = md.D2;
          op_d    = md.MDOP;
          cnt_d   = go_div ? CW'(DIV_CYCLES)
                           : CW'(MULT_CYCLES);
          state_d = RUN;
        end else if (md.MDOP == OP_MTHI) begin
          hi_d = md.D1;
        end else if (md.MDOP == OP_MTLO) begin
          lo_d = md.D1;
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          if (res_wr) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign md.BUSY = (state_q == RUN);
  assign md.HI   = hi_q;
  assign md.LO   = lo_q;

endmodule

// File: tb/tb_mult_div.sv
// Self-checking bench for mult_div: directed table, corner sequences,
// and random ops against an arithmetic HI/LO model.
module tb_mult_div;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  mult_div_if md();

  mult_div #(
    .MULT_CYCLES(MC),
    .DIV_CYCLES (DC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .md   (md)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } vec_t;

  vec_t tbl[11];

  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int          m_n;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h",
               nm, act, exp);
    end
  endtask

  task automatic model(logic [2:0] op, logic [31:0] a,
                       logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    m_n = 0;
    case (op)
      3'd1: begin
        p = sa * sb;
        m_hi = p[63:32];
        m_lo = p[31:0];
        m_n = MC;
      end
      3'd2: begin
        p = 64'(a) * 64'(b);
        m_hi = p[63:32];
        m_lo = p[31:0];
        m_n = MC;
      end
      3'd3: begin
        if (b != 0) begin
          q = sa / sb;
          r = sa % sb;
          m_lo = q[31:0];
          m_hi = r[31:0];
        end
        m_n = DC;
      end
      3'd4: begin
        if (b != 0) begin
          m_lo = a / b;
          m_hi = a % b;
        end
        m_n = DC;
      end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic run_op(logic [2:0] op, logic [31:0] a,
                        logic [31:0] b, output int n);
    @(negedge clk);
    md.START = 1'b1;
    md.MDOP  = op;
    md.D1    = a;
    md.D2    = b;
    @(negedge clk);
    n = 0;
    while (md.BUSY && n < 100) begin
      n++;
      md.START = 1'($urandom_range(0, 1));
      md.MDOP  = 3'($urandom_range(0, 7));
      md.D1    = $urandom;
      md.D2    = $urandom;
      @(negedge clk);
    end
    md.START = 1'b0;
    md.MDOP  = 3'd0;
  endtask

  task automatic mt(logic [2:0] op, logic [31:0] v);
    @(negedge clk);
    md.MDOP = op;
    md.D1   = v;
    @(negedge clk);
    md.MDOP = 3'd0;
  endtask

  task automatic apply(logic [2:0] op, logic [31:0] a,
                       logic [31:0] b, output int n);
    n = 0;
    if (op >= 3'd1 && op <= 3'd4) run_op(op, a, b, n);
    else mt(op, a);
  endtask

  initial begin
    int n;
    logic [2:0] op;
    logic [31:0] a;
    logic [31:0] b;

    tests = 0;
    fails = 0;
    tbl[0]  = '{3'd1, 32'hFFFFFFFE, 32'h3,
                32'hFFFFFFFF, 32'hFFFFFFFA, MC};
    tbl[1]  = '{3'd2, 32'hFFFFFFFE, 32'h3,
                32'h00000002, 32'hFFFFFFFA, MC};
    tbl[2]  = '{3'd3, 32'hFFFFFFF9, 32'h2,
                32'hFFFFFFFF, 32'hFFFFFFFD, DC};
    tbl[3]  = '{3'd5, 32'h12345678, 32'h0,
                32'h12345678, 32'hFFFFFFFD, 0};
    tbl[4]  = '{3'd6, 32'h9ABCDEF0, 32'h0,
                32'h12345678, 32'h9ABCDEF0, 0};
    tbl[5]  = '{3'd4, 32'h00000055, 32'h0,
                32'h12345678, 32'h9ABCDEF0, DC};
    tbl[6]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF,
                32'h00000000, 32'h80000000, DC};
    tbl[7]  = '{3'd4, 32'hFFFFFFF9, 32'h2,
                32'h00000001, 32'h7FFFFFFC, DC};
    tbl[8]  = '{3'd3, 32'h00000007, 32'hFFFFFFFE,
                32'h00000001, 32'hFFFFFFFD, DC};
    tbl[9]  = '{3'd3, 32'h00000005, 32'h0,
                32'h00000001, 32'hFFFFFFFD, DC};
    tbl[10] = '{3'd1, 32'h80000000, 32'h80000000,
                32'h40000000, 32'h00000000, MC};

    reset    = 1'b1;
    md.START = 1'b0;
    md.MDOP  = 3'd0;
    md.D1    = 32'd0;
    md.D2    = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 32'(md.BUSY), 32'd0);
    chk("rst_hi", md.HI, 32'd0);
    chk("rst_lo", md.LO, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;

    for (int i = 0; i < 11; i++) begin
      apply(tbl[i].op, tbl[i].a, tbl[i].b, n);
      model(tbl[i].op, tbl[i].a, tbl[i].b);
      chk($sformatf("tbl%0d_n", i), 32'(n), 32'(tbl[i].n));
      chk($sformatf("tbl%0d_hi", i), md.HI, tbl[i].hi);
      chk($sformatf("tbl%0d_lo", i), md.LO, tbl[i].lo);
    end

    // START with non-arith ops must not go busy.
    @(negedge clk);
    md.START = 1'b1;
    md.MDOP  = 3'd7;
    md.D1    = 32'hAAAA5555;
    @(negedge clk);
    chk("st7_busy", 32'(md.BUSY), 32'd0);
    md.MDOP = 3'd0;
    @(negedge clk);
    chk("st0_busy", 32'(md.BUSY), 32'd0);
    md.MDOP = 3'd5;
    @(negedge clk);
    md.START = 1'b0;
    md.MDOP  = 3'd0;
    model(3'd5, 32'hAAAA5555, 32'd0);
    chk("stmthi_busy", 32'(md.BUSY), 32'd0);
    chk("stmthi_hi", md.HI, m_hi);
    chk("stmthi_lo", md.LO, m_lo);

    // MULTU in flight ignores START+DIV and MTLO.
    a = 32'hFFFFFFFE;
    b = 32'h00000003;
    model(3'd2, a, b);
    @(negedge clk);
    md.START = 1'b1;
    md.MDOP  = 3'd2;
    md.D1    = a;
    md.D2    = b;
    @(negedge clk);
    n = 0;
    while (md.BUSY && n < 100) begin
      n++;
      md.START = 1'b0;
      md.MDOP  = 3'd0;
      if (n == 2) begin
        md.START = 1'b1;
        md.MDOP  = 3'd3;
        md.D1    = 32'h00000064;
        md.D2    = 32'h00000007;
      end else if (n == 3) begin
        md.MDOP = 3'd6;
        md.D1   = 32'hDEADBEEF;
      end
      @(negedge clk);
    end
    md.START = 1'b0;
    md.MDOP  = 3'd0;
    chk("ign_n", 32'(n), 32'(MC));
    chk("ign_hi", md.HI, m_hi);
    chk("ign_lo", md.LO, m_lo);
    @(negedge clk);
    chk("ign_idle", 32'(md.BUSY), 32'd0);

    // Reset mid-DIV, with a same-cycle START it must override.
    @(negedge clk);
    md.START = 1'b1;
    md.MDOP  = 3'd3;
    md.D1    = 32'hFFFFFFF9;
    md.D2    = 32'h00000002;
    @(negedge clk);
    md.START = 1'b0;
    md.MDOP  = 3'd0;
    n = 1;
    while (n < 3) begin
      n++;
      @(negedge clk);
    end
    reset    = 1'b1;
    md.START = 1'b1;
    md.MDOP  = 3'd1;
    @(negedge clk);
    reset    = 1'b0;
    md.START = 1'b0;
    md.MDOP  = 3'd0;
    chk("mrst_busy", 32'(md.BUSY), 32'd0);
    chk("mrst_hi", md.HI, 32'd0);
    chk("mrst_lo", md.LO, 32'd0);
    repeat (DC) @(negedge clk);
    chk("mrst_hold_busy", 32'(md.BUSY), 32'd0);
    chk("mrst_hold_lo", md.LO, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    apply(3'd1, 32'hFFFFFFFE, 32'h3, n);
    model(3'd1, 32'hFFFFFFFE, 32'h3);
    chk("post_n", 32'(n), 32'(MC));
    chk("post_hi", md.HI, m_hi);
    chk("post_lo", md.LO, m_lo);

    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(1, 6));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 5) == 0) a = 32'h80000000;
      if ($urandom_range(0, 5) == 0) b = 32'hFFFFFFFF;
      apply(op, a, b, n);
      model(op, a, b);
      chk($sformatf("rnd%0d_op%0d_n", i, op),
          32'(n), 32'(m_n));
      chk($sformatf("rnd%0d_op%0d_hi", i, op), md.HI, m_hi);
      chk($sformatf("rnd%0d_op%0d_lo", i, op), md.LO, m_lo);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
